// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared state encoding and port-select constants for the
// fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Port identifiers carried in the grant register.
    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports, memory-side bus and status of the arbiter.
//
// Handshake: a requester raises *_req with its payload (address, we, wdata)
// stable and holds it until the matching *_ack. The ack is a single-cycle
// pulse, and for reads the matching *_rdata is valid in that same cycle and
// is held until the port's next read ack. A req that is dropped before it is
// granted is withdrawn silently and never gets an ack.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    logic                  f_req;
    logic [ADDR_WIDTH-1:0] f_addr;
    logic                  f_ack;
    logic [DATA_WIDTH-1:0] f_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_ack;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic                  mem_oe;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  busy;

    // Arbiter side.
    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output f_ack, f_rdata, d_ack, d_rdata,
        output mem_oe, mem_we, mem_addr, mem_wdata, busy
    );

    // Requesters plus memory side.
    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  f_ack, f_rdata, d_ack, d_rdata,
        input  mem_oe, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_arbiter_pick.sv
// mem_arb_pick: combinational grant selection between the fetch and data
// ports. Default build: data has priority until the starve counter reaches
// STARVE_MAX, then a waiting fetch wins. With MEM_ARB_RR_EN defined: strict
// round-robin, rr_ptr names the port that wins the next tie.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             f_req,
    input  logic             d_req,
`ifdef MEM_ARB_RR_EN
    input  logic             rr_ptr,
`else
    input  logic [CNT_W-1:0] starve_cnt,
`endif
    output logic             grant_valid,
    output logic             grant_port
);

    // Pick the winner among the currently pending requests.
    always_comb begin
        grant_valid = f_req | d_req;
        grant_port  = PORT_F;
`ifdef MEM_ARB_RR_EN
        if (f_req && d_req)
            grant_port = rr_ptr;
        else if (d_req)
            grant_port = PORT_D;
`else
        if (d_req && !(f_req && (starve_cnt == CNT_W'(STARVE_MAX))))
            grant_port = PORT_D;
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one registered single-port memory between a fetch
// port (read only) and a data port (read/write). Each access runs
// IDLE -> ACCESS -> RESP, so at most one access every three cycles.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration instead of
// data priority with a fetch starvation limit.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;
    localparam logic [1:0] S_RESP   = ST_RESP;

    logic [1:0]            state;
    logic                  port_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] f_rdata_q;
    logic [DATA_WIDTH-1:0] d_rdata_q;
    logic                  grant_valid;
    logic                  grant_port;
    logic                  take;
    logic                  f_ack_i;
    logic                  d_ack_i;

    // Requests are only looked at in IDLE.
    assign take = (state == S_IDLE) && grant_valid;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (1)
    ) u_pick (
        .f_req       (bus.f_req),
        .d_req       (bus.d_req),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // After every grant the other port gets priority on the next tie.
    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= PORT_F;
        else if (take)
            rr_ptr <= ~grant_port;
    end
`else
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .f_req       (bus.f_req),
        .d_req       (bus.d_req),
        .starve_cnt  (starve_cnt),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    // Count data grants taken while fetch waits; a fetch grant or an idle fetch port clears it.
    always_ff @(posedge clk) begin
        if (rst || !bus.f_req)
            starve_cnt <= '0;
        else if (take) begin
            if (grant_port == PORT_F)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`endif

    // Access sequencer: latch the winner in IDLE, drive memory in ACCESS, capture read data in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            port_q    <= PORT_F;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        state  <= S_ACCESS;
                        port_q <= grant_port;
                        if (grant_port == PORT_D) begin
                            we_q    <= bus.d_we;
                            addr_q  <= bus.d_addr;
                            wdata_q <= bus.d_wdata;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= bus.f_addr;
                        end
                    end
                end
                S_ACCESS: state <= S_RESP;
                S_RESP: begin
                    state <= S_IDLE;
                    if (port_q == PORT_F)
                        f_rdata_q <= bus.mem_rdata;
                    else if (!we_q)
                        d_rdata_q <= bus.mem_rdata;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A reset arriving during RESP swallows the ack, so the ack is gated by rst.
    assign f_ack_i = (state == S_RESP) && (port_q == PORT_F) && !rst;
    assign d_ack_i = (state == S_RESP) && (port_q == PORT_D) && !rst;

    assign bus.f_ack     = f_ack_i;
    assign bus.d_ack     = d_ack_i;
    // Memory data is passed straight through in the ack cycle, then held in the register.
    assign bus.f_rdata   = f_ack_i ? bus.mem_rdata : f_rdata_q;
    assign bus.d_rdata   = (d_ack_i && !we_q) ? bus.mem_rdata : d_rdata_q;
    assign bus.mem_oe    = (state == S_ACCESS);
    assign bus.mem_we    = (state == S_ACCESS) && (port_q == PORT_D) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = (state != S_IDLE);
    assign dbg_state     = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench for mem_arbiter with a
// memory model, an expected-response queue per port and an ack monitor.
module tb_mem_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 10;
    localparam int SMAX = 4;

    typedef struct packed {
        logic          rd;
        logic [DW-1:0] data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    mem_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    exp_t          exp_f_q[$];
    exp_t          exp_d_q[$];
    logic          grant_log[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] last_rd;
    exp_t          mon_e;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            oe_cnt   = 0;
    int            we_cnt   = 0;

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Registered memory: address sampled in ACCESS, read data presented next cycle.
    initial bus.mem_rdata = '0;
    always @(posedge clk) begin
        if (bus.mem_oe) begin
            if (bus.mem_we)
                mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    // Monitor / scoreboard: every ack pops the expected response of its port.
    always @(negedge clk) begin
        if (rst)
            last_rd = '0;
        if (bus.mem_oe) oe_cnt++;
        if (bus.mem_we) we_cnt++;
        if (bus.f_ack) begin
            grant_log.push_back(1'b0);
            if (exp_f_q.size() == 0)
                check("f_unexpected_ack", 32'(1), 32'(0));
            else begin
                mon_e = exp_f_q.pop_front();
                check("f_rdata", 32'(bus.f_rdata), 32'(mon_e.data));
            end
        end
        if (bus.d_ack) begin
            grant_log.push_back(1'b1);
            if (exp_d_q.size() == 0)
                check("d_unexpected_ack", 32'(1), 32'(0));
            else begin
                mon_e = exp_d_q.pop_front();
                if (mon_e.rd) begin
                    check("d_rdata", 32'(bus.d_rdata), 32'(mon_e.data));
                    last_rd = mon_e.data;
                end else begin
                    check("d_wr_keeps_rdata", 32'(bus.d_rdata), 32'(last_rd));
                end
            end
        end
    end

    // Drivers
    task automatic do_fetch(input logic [AW-1:0] a);
        int k;
        @(posedge clk); #1;
        bus.f_req  = 1'b1;
        bus.f_addr = a;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.f_ack && k < 60);
        if (!bus.f_ack)
            check("f_ack_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        bus.f_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int k;
        @(posedge clk); #1;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.d_ack && k < 60);
        if (!bus.d_ack)
            check("d_ack_timeout", 32'(0), 32'(1));
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    task automatic issue_fetch(input logic [AW-1:0] a);
        exp_f_q.push_back({1'b1, ref_mem[a]});
        do_fetch(a);
    endtask

    task automatic issue_data(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        if (we) begin
            ref_mem[a] = wd;
            exp_d_q.push_back({1'b0, {DW{1'b0}}});
        end else begin
            exp_d_q.push_back({1'b1, ref_mem[a]});
        end
        do_data(we, a, wd);
    endtask

    initial begin
        int   k;
        int   oe0;
        int   we0;
        int   starve;
        logic exp_seq[10];

        rst         = 1'b1;
        bus.f_req   = 1'b0;
        bus.f_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        last_rd     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_acks", 32'({bus.f_ack, bus.d_ack}), 32'(0));
        check("rst_rdata", 32'({bus.f_rdata, bus.d_rdata}), 32'(0));
        check("rst_mem_en", 32'({bus.mem_oe, bus.mem_we}), 32'(0));
        check("rst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 32'(0));

        // Directed write 0x005 <- 0xA5: mem_we in the cycle after sampling, ack one cycle later
        ref_mem[5] = 8'hA5;
        exp_d_q.push_back({1'b0, {DW{1'b0}}});
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h005; bus.d_wdata = 8'hA5;
        @(negedge clk);
        check("wr_idle_mem_oe", 32'(bus.mem_oe), 32'(0));
        @(negedge clk);
        check("wr_access_mem_we", 32'(bus.mem_we), 32'(1));
        check("wr_access_addr", 32'(bus.mem_addr), 32'(10'h005));
        check("wr_access_wdata", 32'(bus.mem_wdata), 32'(8'hA5));
        check("wr_access_busy", 32'(bus.busy), 32'(1));
        check("wr_access_no_ack", 32'(bus.d_ack), 32'(0));
        @(negedge clk);
        check("wr_resp_ack", 32'(bus.d_ack), 32'(1));
        check("wr_resp_mem_we", 32'(bus.mem_we), 32'(0));
        @(posedge clk); #1;
        bus.d_req = 1'b0;

        // Directed fetch of 0x005 returns 0xA5 with ack two cycles after sampling
        exp_f_q.push_back({1'b1, 8'hA5});
        @(posedge clk); #1;
        bus.f_req = 1'b1; bus.f_addr = 10'h005;
        @(negedge clk);
        @(negedge clk);
        check("rd_access_oe_no_we", 32'({bus.mem_oe, bus.mem_we}), 32'(2'b10));
        @(negedge clk);
        check("rd_resp_ack", 32'(bus.f_ack), 32'(1));
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        @(negedge clk);
        check("rd_rdata_held", 32'(bus.f_rdata), 32'(8'hA5));
        check("rd_ack_one_cycle", 32'(bus.f_ack), 32'(0));

        // Preload both address regions with non-zero data
        for (int a = 0; a < 16; a++) begin
            issue_data(1'b1, AW'(a), DW'($urandom_range(1, 255)));
            issue_data(1'b1, AW'(32'h200 + a), DW'($urandom_range(1, 255)));
        end

        // Random concurrent traffic: fetch reads 0x200.., data reads/writes 0x000..
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    issue_fetch(AW'(32'h200 + $urandom_range(0, 15)));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    if ($urandom_range(0, 1) == 1)
                        issue_data(1'b1, AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
                    else
                        issue_data(1'b0, AW'($urandom_range(0, 15)), '0);
                end
            end
        join
        repeat (6) @(posedge clk);
        check("f_queue_drained", 32'(exp_f_q.size()), 32'(0));
        check("d_queue_drained", 32'(exp_d_q.size()), 32'(0));

        // Data request raised during a fetch and withdrawn before it could be sampled
        exp_f_q.push_back({1'b1, ref_mem[10'h201]});
        oe0 = oe_cnt;
        we0 = we_cnt;
        @(posedge clk); #1;
        bus.f_req = 1'b1; bus.f_addr = 10'h201;
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 10'h3FF; bus.d_wdata = 8'h5A;
        @(posedge clk); #1;
        bus.d_req = 1'b0;
        bus.f_req = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("drop_mem_accesses", 32'(oe_cnt - oe0), 32'(1));
        check("drop_mem_writes", 32'(we_cnt - we0), 32'(0));
        check("drop_f_done", 32'(exp_f_q.size()), 32'(0));

        // Reset pulsed in RESP of a data read: no ack, rdata cleared, idle afterwards
        @(posedge clk); #1;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h003;
        @(negedge clk);
        @(negedge clk);
        check("rstresp_access_busy", 32'(bus.busy), 32'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstresp_no_ack", 32'({bus.f_ack, bus.d_ack}), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        check("rstresp_d_rdata", 32'(bus.d_rdata), 32'(0));
        check("rstresp_busy", 32'(bus.busy), 32'(0));
        check("rstresp_f_rdata", 32'(bus.f_rdata), 32'(0));

        // Both requests held continuously: grant order from the arbitration rule
        for (int i = 0; i < 10; i++) begin
            exp_f_q.push_back({1'b1, ref_mem[10'h200]});
            exp_d_q.push_back({1'b1, ref_mem[10'h000]});
        end
`ifdef MEM_ARB_RR_EN
        for (int i = 0; i < 10; i++)
            exp_seq[i] = (i % 2 == 1);
`else
        starve = 0;
        for (int i = 0; i < 10; i++) begin
            if (starve == SMAX) begin
                exp_seq[i] = 1'b0;
                starve = 0;
            end else begin
                exp_seq[i] = 1'b1;
                starve++;
            end
        end
`endif
        grant_log.delete();
        @(posedge clk); #1;
        bus.f_req = 1'b1; bus.f_addr = 10'h200;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h000;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (grant_log.size() < 10 && k < 200);
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("seq_count", 32'(grant_log.size()), 32'(10));
        for (int i = 0; i < 10; i++)
            if (i < grant_log.size())
                check($sformatf("grant_seq_%0d", i), 32'(grant_log[i]), 32'(exp_seq[i]));
        exp_f_q.delete();
        exp_d_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
